// File: rtl/ahb_mtx_input_hold_stage_pkg.sv
// Shared encodings for the bus-matrix input hold stage: AHB transfer, burst and
// response codes plus the hold FSM state type.
package ahb_mtx_input_hold_stage_pkg;

   localparam logic [1:0] TRN_IDLE   = 2'b00;
   localparam logic [1:0] TRN_BUSY   = 2'b01;
   localparam logic [1:0] TRN_NONSEQ = 2'b10;
   localparam logic [1:0] TRN_SEQ    = 2'b11;

   localparam logic [2:0] BUR_SINGLE = 3'b000;
   localparam logic [2:0] BUR_INCR   = 3'b001;
   localparam logic [2:0] BUR_INCR4  = 3'b011;

   localparam logic RESP_OKAY  = 1'b0;
   localparam logic RESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_HELD = 2'b01,
      ST_DATA = 2'b10
   } hold_state_e;

   // NONSEQ and SEQ are the only transfer types that carry real work.
   function automatic logic is_active_trans(input logic [1:0] trans);
      return trans[1];
   endfunction

endpackage

// File: rtl/ahb_mtx_input_hold_stage_if.sv
// Master-side AHB slave-port signals of one bus-matrix input stage.
interface ahb_mtx_input_hold_stage_if #(
   parameter int ADDR_WIDTH = 32
) ();

   logic                  HSELS;
   logic [ADDR_WIDTH-1:0] HADDRS;
   logic [1:0]            HTRANSS;
   logic                  HWRITES;
   logic [2:0]            HSIZES;
   logic [2:0]            HBURSTS;
   logic [3:0]            HPROTS;
   logic                  HMASTLOCKS;
   logic                  HREADYS;
   logic                  HREADYOUTS;
   logic                  HRESPS;

   modport master (
      output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
             HMASTLOCKS, HREADYS,
      input  HREADYOUTS, HRESPS
   );

   modport slave (
      input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
             HMASTLOCKS, HREADYS,
      output HREADYOUTS, HRESPS
   );

endinterface

// File: rtl/ahb_mtx_input_hold_stage.sv
// Per-master input stage of the AHB bus matrix: holds an address phase the
// target port cannot accept yet, requests the port and stalls the master.
module ahb_mtx_input_hold_stage
   import ahb_mtx_input_hold_stage_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   ahb_mtx_input_hold_stage_if.slave ahb,
   input  logic                  active_op,
   input  logic                  hready_op,
   input  logic                  hresp_op,
   output logic                  req_op,
   output logic                  sel_op,
   output logic [ADDR_WIDTH-1:0] addr_op,
   output logic [1:0]            trans_op,
   output logic                  write_op,
   output logic [2:0]            size_op,
   output logic [2:0]            burst_op,
   output logic [3:0]            prot_op,
   output logic                  mastlock_op,
   output logic                  held_tran_op
);

   hold_state_e           state;
   logic [ADDR_WIDTH-1:0] hold_addr;
   logic [1:0]            hold_trans;
   logic                  hold_write;
   logic [2:0]            hold_size;
   logic [2:0]            hold_burst;
   logic [3:0]            hold_prot;
   logic                  hold_lock;
   logic                  valid_in;
   logic                  held;

   assign valid_in = ahb.HSELS & ahb.HREADYS & is_active_trans(ahb.HTRANSS);
   assign held     = (state == ST_HELD);

   // Every accepted address phase is captured so it is ready if the port refuses it.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         hold_addr  <= '0;
         hold_trans <= TRN_IDLE;
         hold_write <= 1'b0;
         hold_size  <= '0;
         hold_burst <= BUR_SINGLE;
         hold_prot  <= '0;
         hold_lock  <= 1'b0;
      end else if (ahb.HREADYS) begin
         hold_addr  <= ahb.HADDRS;
         hold_trans <= ahb.HTRANSS;
         hold_write <= ahb.HWRITES;
         hold_size  <= ahb.HSIZES;
         hold_burst <= ahb.HBURSTS;
         hold_prot  <= ahb.HPROTS;
         hold_lock  <= ahb.HMASTLOCKS;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (valid_in) state <= active_op ? ST_DATA : ST_HELD;
            end
            ST_HELD: begin
               if (active_op) state <= ST_DATA;
            end
            ST_DATA: begin
               // The closing ERROR beat drops any transfer that would otherwise wait in HELD.
               if (hready_op) begin
                  if (valid_in && active_op)                state <= ST_DATA;
                  else if (valid_in && (hresp_op == RESP_OKAY)) state <= ST_HELD;
                  else                                      state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      req_op       = valid_in | held;
      held_tran_op = held;
      sel_op       = ahb.HSELS;
      addr_op      = ahb.HADDRS;
      trans_op     = ahb.HSELS ? ahb.HTRANSS : TRN_IDLE;
      write_op     = ahb.HWRITES;
      size_op      = ahb.HSIZES;
      burst_op     = ahb.HBURSTS;
      prot_op      = ahb.HPROTS;
      mastlock_op  = ahb.HMASTLOCKS;
      if (held) begin
         sel_op      = 1'b1;
         addr_op     = hold_addr;
         write_op    = hold_write;
         size_op     = hold_size;
         prot_op     = hold_prot;
         mastlock_op = hold_lock;
         // A stalled SEQ beat restarts as an INCR burst so the arbiter recounts beats.
         if (hold_trans == TRN_SEQ) begin
            trans_op = TRN_NONSEQ;
            burst_op = BUR_INCR;
         end else begin
            trans_op = hold_trans;
            burst_op = hold_burst;
         end
      end
   end

   always_comb begin
      ahb.HREADYOUTS = 1'b1;
      ahb.HRESPS     = RESP_OKAY;
      case (state)
         ST_HELD: ahb.HREADYOUTS = 1'b0;
         ST_DATA: begin
            ahb.HREADYOUTS = hready_op;
            ahb.HRESPS     = hresp_op;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ahb_mtx_input_hold_stage.sv
// Bench for the bus-matrix input hold stage: forwarded transfers are checked
// against a scoreboard, stall/error/reset behaviour against fixed values.
module tb_ahb_mtx_input_hold_stage;
   import ahb_mtx_input_hold_stage_pkg::*;

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  trans;
      logic [2:0]  burst;
      logic        lock;
      logic        held;
   } sb_item_t;

   logic        HCLK;
   logic        HRESETn;
   logic        active_op;
   logic        hready_op;
   logic        hresp_op;
   logic        req_op;
   logic        sel_op;
   logic [31:0] addr_op;
   logic [1:0]  trans_op;
   logic        write_op;
   logic [2:0]  size_op;
   logic [2:0]  burst_op;
   logic [3:0]  prot_op;
   logic        mastlock_op;
   logic        held_tran_op;

   sb_item_t    sb_q[$];
   int          n_compared   = 0;
   int          n_mismatched = 0;

   ahb_mtx_input_hold_stage_if #(.ADDR_WIDTH(32)) ahb ();

   // The master sees the stage's own HREADYOUT as system HREADY.
   assign ahb.HREADYS = ahb.HREADYOUTS;

   ahb_mtx_input_hold_stage #(.ADDR_WIDTH(32)) dut (
      .HCLK         (HCLK),
      .HRESETn      (HRESETn),
      .ahb          (ahb),
      .active_op    (active_op),
      .hready_op    (hready_op),
      .hresp_op     (hresp_op),
      .req_op       (req_op),
      .sel_op       (sel_op),
      .addr_op      (addr_op),
      .trans_op     (trans_op),
      .write_op     (write_op),
      .size_op      (size_op),
      .burst_op     (burst_op),
      .prot_op      (prot_op),
      .mastlock_op  (mastlock_op),
      .held_tran_op (held_tran_op)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      n_compared++;
      if (observed !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic busIdle();
      ahb.HSELS      = 1'b0;
      ahb.HTRANSS    = TRN_IDLE;
      ahb.HADDRS     = 32'h0;
      ahb.HWRITES    = 1'b0;
      ahb.HSIZES     = 3'b000;
      ahb.HBURSTS    = BUR_SINGLE;
      ahb.HPROTS     = 4'b0000;
      ahb.HMASTLOCKS = 1'b0;
   endtask

   // Drive one address phase; transfers the bench expects to be granted are queued
   // with the form the output port should see (stalled SEQ beats become NONSEQ/INCR).
   task automatic applyStimulus(input logic [1:0] trans, input logic [31:0] addr,
                                input logic [2:0] burst, input logic lock,
                                input logic grant_now, input bit will_hold,
                                input bit expect_fwd);
      sb_item_t item;
      ahb.HSELS      = 1'b1;
      ahb.HTRANSS    = trans;
      ahb.HADDRS     = addr;
      ahb.HWRITES    = 1'b1;
      ahb.HSIZES     = 3'b010;
      ahb.HBURSTS    = burst;
      ahb.HPROTS     = 4'b0011;
      ahb.HMASTLOCKS = lock;
      active_op      = grant_now;
      if (expect_fwd) begin
         item.addr  = addr;
         item.trans = (will_hold && trans == TRN_SEQ) ? TRN_NONSEQ : trans;
         item.burst = (will_hold && trans == TRN_SEQ) ? BUR_INCR : burst;
         item.lock  = lock;
         item.held  = will_hold;
         sb_q.push_back(item);
      end
   endtask

   // A transfer leaves the stage whenever the port request meets a grant.
   always @(negedge HCLK) begin
      if (HRESETn === 1'b1 && req_op === 1'b1 && active_op === 1'b1) begin
         if (sb_q.size() == 0) begin
            checkOutput("sb_unexpected_fwd", addr_op, 32'hFFFF_FFFF);
         end else begin
            sb_item_t exp_item;
            exp_item = sb_q.pop_front();
            checkOutput("sb_addr",  addr_op,             exp_item.addr);
            checkOutput("sb_trans", 32'(trans_op),       32'(exp_item.trans));
            checkOutput("sb_burst", 32'(burst_op),       32'(exp_item.burst));
            checkOutput("sb_lock",  32'(mastlock_op),    32'(exp_item.lock));
            checkOutput("sb_held",  32'(held_tran_op),   32'(exp_item.held));
            checkOutput("sb_sel",   32'(sel_op),         1);
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      HRESETn   = 1'b0;
      busIdle();
      active_op = 1'b0;
      hready_op = 1'b1;
      hresp_op  = 1'b0;

      repeat (2) @(negedge HCLK);
      checkOutput("rst_hreadyout", 32'(ahb.HREADYOUTS), 1);
      checkOutput("rst_hresp",     32'(ahb.HRESPS),     0);
      checkOutput("rst_req",       32'(req_op),         0);
      checkOutput("rst_sel",       32'(sel_op),         0);
      checkOutput("rst_trans",     32'(trans_op),       0);
      checkOutput("rst_held",      32'(held_tran_op),   0);
      tick();
      HRESETn = 1'b1;

      $display("[TB] pass-through");
      applyStimulus(TRN_NONSEQ, 32'h2000_0000, BUR_SINGLE, 1'b0, 1'b1, 0, 1);
      @(negedge HCLK);
      checkOutput("pt_req", 32'(req_op), 1);
      tick();
      busIdle();
      active_op = 1'b0;
      hready_op = 1'b0;
      @(negedge HCLK);
      checkOutput("pt_wait_hreadyout", 32'(ahb.HREADYOUTS), 0);
      tick();
      hready_op = 1'b1;
      @(negedge HCLK);
      checkOutput("pt_done_hreadyout", 32'(ahb.HREADYOUTS), 1);
      tick();

      $display("[TB] hold");
      applyStimulus(TRN_NONSEQ, 32'h2000_0010, BUR_INCR, 1'b0, 1'b0, 1, 1);
      tick();
      busIdle();
      ahb.HADDRS = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         @(negedge HCLK);
         checkOutput("hold_hreadyout", 32'(ahb.HREADYOUTS), 0);
         checkOutput("hold_req",       32'(req_op),         1);
         checkOutput("hold_addr",      addr_op,             32'h2000_0010);
         checkOutput("hold_held",      32'(held_tran_op),   1);
         tick();
      end
      active_op = 1'b1;
      @(negedge HCLK);
      checkOutput("hold_grant_hreadyout", 32'(ahb.HREADYOUTS), 0);
      tick();
      active_op = 1'b0;
      @(negedge HCLK);
      checkOutput("hold_data_held",      32'(held_tran_op),   0);
      checkOutput("hold_data_hreadyout", 32'(ahb.HREADYOUTS), 1);
      tick();

      $display("[TB] burst rebuild");
      applyStimulus(TRN_NONSEQ, 32'h3000_0000, BUR_INCR4, 1'b0, 1'b1, 0, 1);
      tick();
      applyStimulus(TRN_SEQ, 32'h3000_0004, BUR_INCR4, 1'b0, 1'b1, 0, 1);
      tick();
      applyStimulus(TRN_SEQ, 32'h3000_0008, BUR_INCR4, 1'b0, 1'b0, 1, 1);
      tick();
      busIdle();
      for (int i = 0; i < 2; i++) begin
         @(negedge HCLK);
         checkOutput("rb_trans", 32'(trans_op), 32'(TRN_NONSEQ));
         checkOutput("rb_burst", 32'(burst_op), 32'(BUR_INCR));
         tick();
      end
      active_op = 1'b1;
      tick();
      active_op = 1'b0;
      tick();

      $display("[TB] error response");
      applyStimulus(TRN_NONSEQ, 32'h4000_0000, BUR_SINGLE, 1'b0, 1'b1, 0, 1);
      tick();
      applyStimulus(TRN_NONSEQ, 32'h4000_0010, BUR_SINGLE, 1'b0, 1'b0, 0, 0);
      hready_op = 1'b0;
      hresp_op  = 1'b1;
      @(negedge HCLK);
      checkOutput("err1_hresp",     32'(ahb.HRESPS),     1);
      checkOutput("err1_hreadyout", 32'(ahb.HREADYOUTS), 0);
      tick();
      hready_op = 1'b1;
      @(negedge HCLK);
      checkOutput("err2_hresp",     32'(ahb.HRESPS),     1);
      checkOutput("err2_hreadyout", 32'(ahb.HREADYOUTS), 1);
      tick();
      busIdle();
      hresp_op = 1'b0;
      @(negedge HCLK);
      checkOutput("err_cancel_req",       32'(req_op),         0);
      checkOutput("err_cancel_held",      32'(held_tran_op),   0);
      checkOutput("err_cancel_hreadyout", 32'(ahb.HREADYOUTS), 1);
      checkOutput("err_cancel_hresp",     32'(ahb.HRESPS),     0);
      tick();

      $display("[TB] idle and busy");
      applyStimulus(TRN_BUSY, 32'h7000_0000, BUR_INCR, 1'b0, 1'b0, 0, 0);
      @(negedge HCLK);
      checkOutput("busy_req", 32'(req_op), 0);
      tick();
      applyStimulus(TRN_IDLE, 32'h7000_0004, BUR_INCR, 1'b0, 1'b0, 0, 0);
      @(negedge HCLK);
      checkOutput("idle_req",        32'(req_op),         0);
      checkOutput("idle_after_busy", 32'(ahb.HREADYOUTS), 1);
      tick();
      @(negedge HCLK);
      checkOutput("idle_held", 32'(held_tran_op), 0);
      tick();

      $display("[TB] reset while held");
      applyStimulus(TRN_NONSEQ, 32'h5000_0000, BUR_INCR, 1'b1, 1'b0, 1, 0);
      tick();
      busIdle();
      @(negedge HCLK);
      checkOutput("lock_held_lock", 32'(mastlock_op),     1);
      checkOutput("lock_held_req",  32'(req_op),          1);
      checkOutput("lock_held_addr", addr_op,              32'h5000_0000);
      #2;
      HRESETn = 1'b0;
      #1;
      checkOutput("rst_mid_hreadyout", 32'(ahb.HREADYOUTS), 1);
      checkOutput("rst_mid_req",       32'(req_op),         0);
      checkOutput("rst_mid_trans",     32'(trans_op),       0);
      checkOutput("rst_mid_held",      32'(held_tran_op),   0);
      tick();
      HRESETn = 1'b1;
      applyStimulus(TRN_NONSEQ, 32'h6000_0000, BUR_SINGLE, 1'b0, 1'b1, 0, 1);
      @(negedge HCLK);
      checkOutput("post_rst_held", 32'(held_tran_op), 0);
      tick();
      busIdle();
      active_op = 1'b0;
      tick();
      tick();

      checkOutput("sb_drain", 32'(sb_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
